pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Central pipeline controller for the 3-stage core: S1 decode/fetch, S2 execute, S3 memory/writeback.
- Consumes the hazard unit's load-use stall, the branch-taken result from S2, and the MULT/DIV indicator from S2.
- Produces per-stage register enables, bubble/flush controls and the PC load/enable.
- Sequences multi-cycle MULT/DIV occupancy, retire-time HALT, and a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, total cycles a MULT/DIV occupies S2 (legal range 2..15).
- STALL_CYCLES, 1, cycles the pipe freezes per load-use stall request (legal range 1..3).
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- haz_stall  input  1  load-use stall request from the hazard unit.
- s2_valid  input  1  S2 holds a real (non-bubble) instruction.
- s2_R0_en  input  1  S2 instruction is MULT or DIV.
- branch_taken  input  1  S2 branch resolved taken this cycle.
- s3_opcode  input  types_pkg::opcode_t  opcode retiring in S3.
- s3_valid  input  1  S3 holds a real instruction.
- resume  input  1  single-cycle pulse that leaves HALTED.
- pc_en  output  1  PC register update enable.
- pc_load  output  1  PC takes the branch target.
- s1_en, s2_en, s3_en  output  1 each  pipeline register enables.
- s1_flush  output  1  S1 register loads NOP.
- s2_bubble  output  1  S2 register loads NOP.
- s3_bubble  output  1  S3 register loads NOP.
- md_busy  output  1  MULT/DIV occupying S2.
- halted  output  1  core halted.
- state  output  types_pkg::seq_state_t  current FSM state, for debug.
- stall_cnt  output  PERF_W  saturating count of cycles with pc_en=0 outside HALTED.

Behaviour:
- States: RUN, LD_STALL, MD_BUSY, HALTED. The state register and a 4-bit down-counter `cnt` are clocked on the rising edge of clk with asynchronous reset.
- Reset:
  - While rst is high: state=RUN, cnt=0, stall_cnt=0.
  - Forced outputs during reset: all enables 0, s1_flush=s2_bubble=s3_bubble=1, pc_load=0, md_busy=0, halted=0.
  - Reset asserted mid-MD_BUSY or mid-HALTED aborts immediately. The first cycle after deassert is RUN.
- Outputs are Mealy: a function of state and current-cycle inputs.
- RUN, with defaults of all enables 1, flushes 0, and the following priority, highest first:
  1. branch_taken & s2_valid: pc_load=1, s1_flush=1, s2_bubble=1. State stays RUN. haz_stall is ignored this cycle.
  2. s2_valid & s2_R0_en: pc_en=s1_en=s2_en=0, s3_bubble=1, md_busy=1, cnt<=MD_LATENCY-2. Next state MD_BUSY.
  3. haz_stall: pc_en=s1_en=0, s2_bubble=1. If STALL_CYCLES>1, cnt<=STALL_CYCLES-2 and next state LD_STALL; otherwise stay RUN.
  4. s3_valid & s3_opcode==HALT: the HALT retires this cycle with normal enables. Next state HALTED.
- LD_STALL:
  - Outputs identical to RUN case 3.
  - If cnt==0, next state RUN; otherwise cnt decrements.
  - branch_taken and s2_R0_en are ignored because S2 holds a bubble.
- MD_BUSY:
  - Outputs identical to RUN case 2.
  - If cnt==0, next state RUN, and S2 advances in the following cycle. Otherwise cnt decrements.
  - Occupancy totals exactly MD_LATENCY cycles, counting the entry cycle.
  - branch_taken and haz_stall are ignored.
- HALTED:
  - All enables 0, flushes 0, halted=1.
  - On resume, next state RUN. resume is ignored in every other state.
- stall_cnt:
  - Increments every cycle that pc_en==0 and state!=HALTED.
  - Saturates at 2^PERF_W-1 and does not wrap.
- HALT and MULT/DIV in the same cycle (HALT in S3, MULT/DIV in S2): the MULT/DIV rule wins and the HALT still retires. Because S3 is bubbled behind it, the HALT is not seen again, so the halt is lost.
  - Required fix: HALTED takes priority over MD_BUSY entry. In this case the FSM enters HALTED.
  - On resume, the FSM returns to RUN, re-evaluates s2_R0_en, and enters MD_BUSY.

Decomposition:
- types_pkg gains:
  - seq_state_t, an enum {RUN, LD_STALL, MD_BUSY, HALTED} of 2 bits.
  - HALT in opcode_t, if not already present.
- The MD_LATENCY and STALL_CYCLES defaults are exposed as localparams in types_pkg.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) implements stall_cnt.
- The FSM and enable logic stay in pipeline_sequencer.

Test Plan:
1. Reset during MD_BUSY (rst high at cycle 2 of 4) -> outputs at reset values immediately; state=RUN on the first cycle after release; stall_cnt=0.
2. MULT in S2 with s2_valid=1 and MD_LATENCY=4 -> pc_en=s2_en=0 and md_busy=1 for exactly 4 cycles; s3_bubble=1 each cycle; stall_cnt=4; RUN on cycle 5.
3. haz_stall for one cycle with STALL_CYCLES=1 -> pc_en=s1_en=0 and s2_bubble=1 for 1 cycle; stall_cnt +1. With STALL_CYCLES=3 -> frozen for 3 cycles.
4. branch_taken and haz_stall together -> pc_load=1, s1_flush=1, s2_bubble=1, pc_en=1; no stall counted.
5. HALT retires -> halted=1 from the next cycle; enables 0 for 10 cycles; stall_cnt unchanged. A resume pulse gives RUN the next cycle.
6. Force stall_cnt to 0xFFFE, then run a 4-cycle MULT -> stall_cnt holds at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the 3-stage core: opcodes, sequencer states and
// the default timing parameters of the pipeline sequencer.
package types_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    LW   = 4'h3,
    SW   = 4'h4,
    BEQ  = 4'h5,
    MULT = 4'h6,
    DIV  = 4'h7,
    HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MD_BUSY  = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam int MD_LATENCY_DEF   = 4;
  localparam int STALL_CYCLES_DEF = 1;
  localparam int SEQ_CNT_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request until the all-ones ceiling, never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller for the 3-stage core. Produces stage
// enables, bubbles/flushes and PC control; sequences load-use stalls,
// multi-cycle MULT/DIV occupancy of S2 and retire-time HALT.
module pipeline_sequencer
  import types_pkg::*;
#(
  parameter int MD_LATENCY   = MD_LATENCY_DEF,
  parameter int STALL_CYCLES = STALL_CYCLES_DEF,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              haz_stall,
  input  logic              s2_valid,
  input  logic              s2_R0_en,
  input  logic              branch_taken,
  input  opcode_t           s3_opcode,
  input  logic              s3_valid,
  input  logic              resume,
  output logic              pc_en,
  output logic              pc_load,
  output logic              s1_en,
  output logic              s2_en,
  output logic              s3_en,
  output logic              s1_flush,
  output logic              s2_bubble,
  output logic              s3_bubble,
  output logic              md_busy,
  output logic              halted,
  output seq_state_t        state,
  output logic [PERF_W-1:0] stall_cnt
);

  // Counter preloads: the entry cycle is spent in RUN, so the counter
  // covers the remaining cycles minus one (terminal count is zero).
  localparam logic [SEQ_CNT_W-1:0] MD_CNT_INIT = SEQ_CNT_W'(MD_LATENCY - 2);
  localparam logic [SEQ_CNT_W-1:0] LD_CNT_INIT =
    SEQ_CNT_W'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);

  seq_state_t           state_nxt;
  logic [SEQ_CNT_W-1:0] cnt;
  logic [SEQ_CNT_W-1:0] cnt_nxt;

  logic halt_retire;
  logic br_redirect;
  logic md_hold;
  logic ld_hold;
  logic in_halt;
  logic stall_inc;

  assign halt_retire = s3_valid && (s3_opcode == HALT);

  // Next-state logic and selection of the output mode for this cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    br_redirect = 1'b0;
    md_hold     = 1'b0;
    ld_hold     = 1'b0;
    in_halt     = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken && s2_valid) begin
          br_redirect = 1'b1;
        end else if (s2_valid && s2_R0_en) begin
          // MULT/DIV is held in S2 either way; a HALT retiring under it
          // wins so the halt is not lost behind the S3 bubble.
          md_hold = 1'b1;
          if (halt_retire) begin
            state_nxt = HALTED;
          end else begin
            state_nxt = MD_BUSY;
            cnt_nxt   = MD_CNT_INIT;
          end
        end else if (haz_stall) begin
          ld_hold = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nxt = LD_STALL;
            cnt_nxt   = LD_CNT_INIT;
          end
        end else if (halt_retire) begin
          state_nxt = HALTED;
        end
      end
      LD_STALL: begin
        ld_hold = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      MD_BUSY: begin
        md_hold = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      HALTED: begin
        in_halt = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Mealy outputs; reset forces every stage to freeze and load NOPs.
  assign pc_en     = !(rst || md_hold || ld_hold || in_halt);
  assign s1_en     = !(rst || md_hold || ld_hold || in_halt);
  assign s2_en     = !(rst || md_hold || in_halt);
  assign s3_en     = !(rst || in_halt);
  assign pc_load   = !rst && br_redirect;
  assign s1_flush  = rst || br_redirect;
  assign s2_bubble = rst || br_redirect || ld_hold;
  assign s3_bubble = rst || md_hold;
  assign md_busy   = !rst && md_hold;
  assign halted    = !rst && in_halt;

  // State and occupancy counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Frozen-PC cycles outside HALTED feed the performance counter.
  assign stall_inc = !pc_en && (state != HALTED);

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: two instances (default parameters and
// MD_LATENCY=3/STALL_CYCLES=3/PERF_W=3) share stimulus; a behavioural
// model tracks remaining freeze cycles and the halt flag per instance.
module tb_pipeline_sequencer;
  import types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst, haz_stall, s2_valid, s2_R0_en, branch_taken, s3_valid, resume;
  opcode_t s3_opcode;

  logic pc_en_a, pc_load_a, s1_en_a, s2_en_a, s3_en_a, s1_flush_a, s2_bubble_a, s3_bubble_a, md_busy_a, halted_a;
  logic pc_en_b, pc_load_b, s1_en_b, s2_en_b, s3_en_b, s1_flush_b, s2_bubble_b, s3_bubble_b, md_busy_b, halted_b;
  seq_state_t  state_a, state_b;
  logic [15:0] stall_cnt_a;
  logic [2:0]  stall_cnt_b;

  pipeline_sequencer dut_a (
    .clk(clk), .rst(rst), .haz_stall(haz_stall), .s2_valid(s2_valid), .s2_R0_en(s2_R0_en),
    .branch_taken(branch_taken), .s3_opcode(s3_opcode), .s3_valid(s3_valid), .resume(resume),
    .pc_en(pc_en_a), .pc_load(pc_load_a), .s1_en(s1_en_a), .s2_en(s2_en_a), .s3_en(s3_en_a),
    .s1_flush(s1_flush_a), .s2_bubble(s2_bubble_a), .s3_bubble(s3_bubble_a), .md_busy(md_busy_a),
    .halted(halted_a), .state(state_a), .stall_cnt(stall_cnt_a)
  );

  pipeline_sequencer #(.MD_LATENCY(3), .STALL_CYCLES(3), .PERF_W(3)) dut_b (
    .clk(clk), .rst(rst), .haz_stall(haz_stall), .s2_valid(s2_valid), .s2_R0_en(s2_R0_en),
    .branch_taken(branch_taken), .s3_opcode(s3_opcode), .s3_valid(s3_valid), .resume(resume),
    .pc_en(pc_en_b), .pc_load(pc_load_b), .s1_en(s1_en_b), .s2_en(s2_en_b), .s3_en(s3_en_b),
    .s1_flush(s1_flush_b), .s2_bubble(s2_bubble_b), .s3_bubble(s3_bubble_b), .md_busy(md_busy_b),
    .halted(halted_b), .state(state_b), .stall_cnt(stall_cnt_b)
  );

  // {pc_en,pc_load,s1_en,s2_en,s3_en,s1_flush,s2_bubble,s3_bubble,md_busy,halted}
  logic [9:0] out_a, out_b;
  assign out_a = {pc_en_a, pc_load_a, s1_en_a, s2_en_a, s3_en_a, s1_flush_a, s2_bubble_a, s3_bubble_a, md_busy_a, halted_a};
  assign out_b = {pc_en_b, pc_load_b, s1_en_b, s2_en_b, s3_en_b, s1_flush_b, s2_bubble_b, s3_bubble_b, md_busy_b, halted_b};

  localparam logic [9:0] O_RST = 10'b0000011100;
  localparam logic [9:0] O_RUN = 10'b1011100000;
  localparam logic [9:0] O_BR  = 10'b1111111000;
  localparam logic [9:0] O_MD  = 10'b0000100110;
  localparam logic [9:0] O_LD  = 10'b0001101000;
  localparam logic [9:0] O_HLT = 10'b0000000001;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining freeze cycles per cause plus halt flag.
  int lat[2]  = '{4, 3};
  int scy[2]  = '{1, 3};
  int maxc[2] = '{65535, 7};
  int m_md[2], m_ld[2], m_cnt[2], n_md[2], n_ld[2], n_cnt[2];
  bit m_halt[2], n_halt[2];

  task automatic model_eval(input int k, output logic [9:0] o, output seq_state_t st, output int c);
    bit halt_ret;
    halt_ret = s3_valid && (s3_opcode == HALT);
    n_md[k] = m_md[k]; n_ld[k] = m_ld[k]; n_halt[k] = m_halt[k];
    if (m_halt[k])      st = HALTED;
    else if (m_md[k] > 0) st = MD_BUSY;
    else if (m_ld[k] > 0) st = LD_STALL;
    else                st = RUN;
    c = m_cnt[k];
    if (rst) begin
      o = O_RST; st = RUN; c = 0;
      n_md[k] = 0; n_ld[k] = 0; n_halt[k] = 0; n_cnt[k] = 0;
    end else begin
      if (m_halt[k]) begin
        o = O_HLT;
        if (resume) n_halt[k] = 0;
      end else if (m_md[k] > 0) begin
        o = O_MD; n_md[k] = m_md[k] - 1;
      end else if (m_ld[k] > 0) begin
        o = O_LD; n_ld[k] = m_ld[k] - 1;
      end else if (branch_taken && s2_valid) begin
        o = O_BR;
      end else if (s2_valid && s2_R0_en) begin
        o = O_MD;
        if (halt_ret) n_halt[k] = 1;
        else          n_md[k] = lat[k] - 1;
      end else if (haz_stall) begin
        o = O_LD; n_ld[k] = scy[k] - 1;
      end else begin
        o = O_RUN;
        if (halt_ret) n_halt[k] = 1;
      end
      n_cnt[k] = m_cnt[k];
      if (!o[9] && !m_halt[k] && m_cnt[k] < maxc[k]) n_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  logic last_pc_a, last_pc_b;

  task automatic sample();
    logic [9:0] eo; seq_state_t es; int ec;
    @(negedge clk);
    model_eval(0, eo, es, ec);
    chk("outs_a", 32'(out_a), 32'(eo));
    chk("state_a", 32'(state_a), 32'(es));
    chk("stall_cnt_a", 32'(stall_cnt_a), 32'(ec));
    model_eval(1, eo, es, ec);
    chk("outs_b", 32'(out_b), 32'(eo));
    chk("state_b", 32'(state_b), 32'(es));
    chk("stall_cnt_b", 32'(stall_cnt_b), 32'(ec));
    last_pc_a = pc_en_a;
    last_pc_b = pc_en_b;
  endtask

  task automatic advance();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      m_md[k] = n_md[k]; m_ld[k] = n_ld[k]; m_halt[k] = n_halt[k]; m_cnt[k] = n_cnt[k];
    end
  endtask

  task automatic drive(input logic r, h, v2, r0, br, v3, hop, res);
    rst = r; haz_stall = h; s2_valid = v2; s2_R0_en = r0; branch_taken = br;
    s3_valid = v3; s3_opcode = hop ? HALT : ADD; resume = res;
  endtask

  task automatic step(input logic r, h, v2, r0, br, v3, hop, res);
    drive(r, h, v2, r0, br, v3, hop, res);
    sample();
    advance();
  endtask

  typedef struct {
    logic       r, h, v2, r0, br, v3, hop, res;
    logic [9:0] out;
    seq_state_t st;
    int         sc;
  } vec_t;

  vec_t tv[22];

  initial begin
    int frz_a, frz_b, held;
    for (int k = 0; k < 2; k++) begin
      m_md[k] = 0; m_ld[k] = 0; m_cnt[k] = 0; m_halt[k] = 0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //         r  h v2 r0 br v3 hop res  out    state     stall_cnt
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, O_RST, RUN,      0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, O_RUN, RUN,      0};
    tv[2]  = '{0, 1, 1, 0, 1, 0, 0, 0, O_BR,  RUN,      0};
    tv[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, O_LD,  RUN,      0};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, O_RUN, RUN,      1};
    tv[5]  = '{0, 0, 1, 1, 0, 0, 0, 0, O_MD,  RUN,      1};
    tv[6]  = '{0, 0, 1, 1, 0, 0, 0, 0, O_MD,  MD_BUSY,  2};
    tv[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, O_MD,  MD_BUSY,  3};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, O_MD,  MD_BUSY,  4};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, O_RUN, RUN,      5};
    tv[10] = '{0, 0, 0, 0, 0, 1, 1, 0, O_RUN, RUN,      5};
    tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, O_HLT, HALTED,   5};
    tv[12] = '{0, 0, 0, 0, 0, 0, 0, 1, O_HLT, HALTED,   5};
    tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, O_RUN, RUN,      5};
    tv[14] = '{0, 0, 1, 1, 0, 1, 1, 0, O_MD,  RUN,      5};
    tv[15] = '{0, 0, 1, 1, 0, 0, 0, 0, O_HLT, HALTED,   6};
    tv[16] = '{0, 0, 1, 1, 0, 0, 0, 1, O_HLT, HALTED,   6};
    tv[17] = '{0, 0, 1, 1, 0, 0, 0, 0, O_MD,  RUN,      6};
    tv[18] = '{0, 0, 0, 0, 0, 0, 0, 0, O_MD,  MD_BUSY,  7};
    tv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, O_MD,  MD_BUSY,  8};
    tv[20] = '{0, 0, 0, 0, 0, 0, 0, 0, O_MD,  MD_BUSY,  9};
    tv[21] = '{0, 0, 0, 0, 0, 0, 0, 0, O_RUN, RUN,     10};

    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].r, tv[i].h, tv[i].v2, tv[i].r0, tv[i].br, tv[i].v3, tv[i].hop, tv[i].res);
      sample();
      chk($sformatf("tbl%0d_outs", i), 32'(out_a), 32'(tv[i].out));
      chk($sformatf("tbl%0d_state", i), 32'(state_a), 32'(tv[i].st));
      chk($sformatf("tbl%0d_cnt", i), 32'(stall_cnt_a), 32'(tv[i].sc));
      advance();
    end

    // Reset in the middle of a MULT occupancy.
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("mdrst_outs", 32'(out_a), 32'(O_RST));
    chk("mdrst_state", 32'(state_a), 32'(RUN));
    chk("mdrst_cnt", 32'(stall_cnt_a), 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("mdrst_after_state", 32'(state_a), 32'(RUN));
    chk("mdrst_after_cnt", 32'(stall_cnt_a), 0);
    advance();

    // Single load-use request: one frozen cycle on A, three on B.
    frz_a = 0; frz_b = 0;
    step(0, 1, 0, 0, 0, 0, 0, 0);
    frz_a += !last_pc_a; frz_b += !last_pc_b;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      frz_a += !last_pc_a; frz_b += !last_pc_b;
    end
    chk("ld_frozen_a", 32'(frz_a), 1);
    chk("ld_frozen_b", 32'(frz_b), 3);
    chk("ld_cnt_a", 32'(stall_cnt_a), 1);
    chk("ld_cnt_b", 32'(stall_cnt_b), 3);

    // HALT: stays halted with enables off and no stall counting.
    step(0, 0, 0, 0, 0, 1, 1, 0);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      if (halted_a && !s1_en_a && !s2_en_a && !s3_en_a && !pc_en_a) held++;
      advance();
    end
    chk("halt_held", 32'(held), 10);
    chk("halt_cnt_a", 32'(stall_cnt_a), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("resume_state_a", 32'(state_a), 32'(RUN));
    advance();

    // Saturation: B's 3-bit counter pins at 7 while A keeps counting.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int rep = 0; rep < 4; rep++) begin
      step(0, 0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
      if (rep == 2) begin
        chk("sat_b_reach", 32'(stall_cnt_b), 7);
        chk("sat_a_12", 32'(stall_cnt_a), 12);
      end
    end
    chk("sat_b_hold", 32'(stall_cnt_b), 7);
    chk("sat_a_16", 32'(stall_cnt_a), 16);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
